// File: rtl/food_placer.sv
`default_nettype none
// ============================================================================
// food_placer: maps LFSR samples to a playfield cell, queries occupancy and
// commits the first free cell. Optional macro FOOD_SCAN_EN adds a raster-scan
// fallback after MAX_TRIES hits and drives the full flag.
// Revision: 1.0
// ============================================================================
module food_placer #(
  parameter int GRID_W    = 24,
  parameter int GRID_H    = 24,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rand_val,    // LFSR sample; "rand" is a reserved word
  input  logic       place_req,
  output logic       busy,
  output logic       done,
  output logic [4:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       full,
  output logic       q_valid,
  output logic [4:0] q_x,
  output logic [4:0] q_y,
  input  logic       q_occ
);

  localparam logic [5:0] c_grid_w6    = 6'(GRID_W);
  localparam logic [5:0] c_grid_h6    = 6'(GRID_H);
  localparam logic [3:0] c_max_tries  = 4'(MAX_TRIES);
`ifdef FOOD_SCAN_EN
  localparam logic [4:0] c_x_last     = 5'(GRID_W - 1);
  localparam logic [4:0] c_y_last     = 5'(GRID_H - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SX     = 3'd1,
    SY     = 3'd2,
    QUERY  = 3'd3,
    CHECK  = 3'd4,
    COMMIT = 3'd5
`ifdef FOOD_SCAN_EN
    ,
    SCAN_Q = 3'd6,
    SCAN_C = 3'd7
`endif
  } state_t;

  // A single conditional subtract suffices because GRID >= 16 and r <= 31.
  function automatic logic [4:0] map_dim(input logic [4:0] r, input logic [5:0] lim);
    logic [5:0] t;
    t = {1'b0, r};
    if (t >= lim) t = t - lim;
    return t[4:0];
  endfunction

  state_t     state_q, state_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic [3:0] tries_q, tries_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [4:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic       q_valid_q, q_valid_d;
  logic [4:0] q_x_q, q_x_d, q_y_q, q_y_d;
`ifdef FOOD_SCAN_EN
  logic       full_q, full_d;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    tries_d      = tries_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
`ifdef FOOD_SCAN_EN
    full_d       = full_q;
`endif
    case (state_q)
      IDLE: begin
        if (place_req) begin
          state_d      = SX;
          busy_d       = 1'b1;
          food_valid_d = 1'b0;
`ifdef FOOD_SCAN_EN
          full_d       = 1'b0;
`endif
        end
      end
      SX: begin
        x_d     = map_dim(rand_val, c_grid_w6);
        state_d = SY;
      end
      SY: begin
        y_d     = map_dim(rand_val, c_grid_h6);
        state_d = QUERY;
      end
      QUERY: state_d = CHECK;
      CHECK: begin
        if (!q_occ) begin
          state_d = COMMIT;
        end else begin
`ifdef FOOD_SCAN_EN
          tries_d = tries_q + 4'd1;
          if (tries_q + 4'd1 == c_max_tries) begin
            x_d     = 5'd0;
            y_d     = 5'd0;
            state_d = SCAN_Q;
          end else begin
            state_d = SX;
          end
`else
          // Counter only tracks attempts here; saturating avoids wrap noise.
          tries_d = (tries_q == c_max_tries) ? tries_q : tries_q + 4'd1;
          state_d = SX;
`endif
        end
      end
      COMMIT: begin
        food_x_d     = x_q;
        food_y_d     = y_q;
        food_valid_d = 1'b1;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        tries_d      = 4'd0;
        state_d      = IDLE;
      end
`ifdef FOOD_SCAN_EN
      SCAN_Q: state_d = SCAN_C;
      SCAN_C: begin
        if (!q_occ) begin
          state_d = COMMIT;
        end else if (x_q == c_x_last) begin
          if (y_q == c_y_last) begin
            full_d       = 1'b1;
            food_valid_d = 1'b0;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            tries_d      = 4'd0;
            state_d      = IDLE;
          end else begin
            x_d     = 5'd0;
            y_d     = y_q + 5'd1;
            state_d = SCAN_Q;
          end
        end else begin
          x_d     = x_q + 5'd1;
          state_d = SCAN_Q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Query strobe is registered: it is high for the whole QUERY/SCAN_Q cycle.
`ifdef FOOD_SCAN_EN
    q_valid_d = (state_d == QUERY) || (state_d == SCAN_Q);
`else
    q_valid_d = (state_d == QUERY);
`endif
    q_x_d = q_valid_d ? x_d : q_x_q;
    q_y_d = q_valid_d ? y_d : q_y_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= 5'd0;
      y_q          <= 5'd0;
      tries_q      <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      food_x_q     <= 5'd0;
      food_y_q     <= 5'd0;
      food_valid_q <= 1'b0;
      q_valid_q    <= 1'b0;
      q_x_q        <= 5'd0;
      q_y_q        <= 5'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tries_q      <= tries_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      q_valid_q    <= q_valid_d;
      q_x_q        <= q_x_d;
      q_y_q        <= q_y_d;
    end
  end

`ifdef FOOD_SCAN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full_q <= 1'b0;
    else        full_q <= full_d;
  end
  assign full = full_q;
`else
  assign full = 1'b0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign q_valid    = q_valid_q;
  assign q_x        = q_x_q;
  assign q_y        = q_y_q;

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// tb_food_placer: directed placements with a scoreboard monitor for done and
// occupancy queries; the bench also plays the occupancy map.
module tb_food_placer;
  localparam int GRID_W = 24;

  logic       clk = 1'b0, reset = 1'b0, place_req = 1'b0, q_occ = 1'b0;
  logic [4:0] rand_val = 5'd0;
  logic       busy, done, food_valid, full, q_valid;
  logic [4:0] food_x, food_y, q_x, q_y;

  food_placer #(.GRID_W(24), .GRID_H(24), .MAX_TRIES(2)) dut (
    .clk(clk), .reset(reset), .rand_val(rand_val), .place_req(place_req),
    .busy(busy), .done(done), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .full(full), .q_valid(q_valid),
    .q_x(q_x), .q_y(q_y), .q_occ(q_occ)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [4:0] x; logic [4:0] y; logic fv; logic fl; logic chk_xy; int cyc; } exp_t;
  typedef struct { logic [4:0] x; logic [4:0] y; } qexp_t;
  exp_t  sb[$];
  qexp_t qq[$];

  int errors = 0, checks = 0, done_cnt = 0;
  int hits_left = 0;
  bit all_occ = 0, have_free = 0;
  logic [4:0] fx = 5'd0, fy = 5'd0;
  logic pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Occupancy map: answer is presented in the cycle after q_valid.
  initial forever begin
    @(negedge clk);
    q_occ = pend;
    if (q_valid) begin
      if (hits_left > 0) begin pend = 1'b1; hits_left--; end
      else if (all_occ)  pend = !(have_free && q_x == fx && q_y == fy);
      else               pend = 1'b0;
    end else begin
      pend = 1'b0;
    end
  end

  initial begin
    exp_t  e;
    qexp_t qe;
    forever begin
      @(negedge clk);
      if (reset && done) begin
        done_cnt++;
        if (sb.size() == 0) check("unexpected_done", done, 0);
        else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("busy_at_done", busy, 0);
          check("food_valid", food_valid, e.fv);
          check("full", full, e.fl);
          if (e.chk_xy) begin
            check("food_x", food_x, e.x);
            check("food_y", food_y, e.y);
          end
        end
      end
      if (reset && q_valid) begin
        if (qq.size() == 0) check("unexpected_query", q_valid, 0);
        else begin
          qe = qq.pop_front();
          check("q_x", q_x, qe.x);
          check("q_y", q_y, qe.y);
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 1400) begin @(negedge clk); k++; end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
    @(negedge clk);
  endtask

  // Two random attempts are scripted; lat is edges from accept to done.
  task automatic place(input logic [4:0] rx0, ry0, qx0, qy0, rx1, ry1, qx1, qy1,
                       input int hits, input bit poke, input int lat,
                       input bit fv, input bit fl, input int scan_cells,
                       input logic [4:0] ex, ey);
    int n, d0;
    d0 = done_cnt;
    @(negedge clk);
    place_req = 1'b1;
    hits_left = hits;
    @(negedge clk);
    place_req = 1'b0;
    n = cyc;
    check("accept_busy", busy, 1);
    check("accept_fv_clear", food_valid, 0);
    check("accept_full_clear", full, 0);
    qq.push_back('{qx0, qy0});
    if (hits > 0 || scan_cells > 0) qq.push_back('{qx1, qy1});
    for (int k = 0; k < scan_cells; k++) qq.push_back('{5'(k % GRID_W), 5'(k / GRID_W)});
    sb.push_back('{ex, ey, fv, fl, fv, n + lat});
    rand_val = rx0;
    @(negedge clk);
    rand_val = ry0;
    if (poke) place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
    rand_val  = 5'd31;
    @(negedge clk);
    @(negedge clk);
    rand_val = rx1;
    @(negedge clk);
    rand_val = ry1;
    @(negedge clk);
    rand_val = 5'd31;
    wait_done(d0 + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_food_x"}, food_x, 0);
    check({tag, "_food_y"}, food_y, 0);
    check({tag, "_food_valid"}, food_valid, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_q_valid"}, q_valid, 0);
    check({tag, "_q_x"}, q_x, 0);
    check({tag, "_q_y"}, q_y, 0);
  endtask

  initial begin
    int n, d0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    place(5'd3,  5'd7,  5'd3,  5'd7,  5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5, 1, 0, 0, 5'd3,  5'd7);
    place(5'd29, 5'd31, 5'd5,  5'd7,  5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5, 1, 0, 0, 5'd5,  5'd7);
    place(5'd23, 5'd23, 5'd23, 5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5, 1, 0, 0, 5'd23, 5'd23);
    place(5'd24, 5'd24, 5'd0,  5'd0,  5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5, 1, 0, 0, 5'd0,  5'd0);
    place(5'd1,  5'd2,  5'd1,  5'd2,  5'd4, 5'd9, 5'd4, 5'd9, 1, 0, 9, 1, 0, 0, 5'd4,  5'd9);

    // place_req held high: back-to-back placements, one per IDLE visit.
    d0 = done_cnt;
    @(negedge clk);
    place_req = 1'b1;
    @(negedge clk);
    n = cyc;
    qq.push_back('{5'd1, 5'd2});
    qq.push_back('{5'd6, 5'd3});
    sb.push_back('{5'd1, 5'd2, 1'b1, 1'b0, 1'b1, n + 5});
    sb.push_back('{5'd6, 5'd3, 1'b1, 1'b0, 1'b1, n + 11});
    rand_val = 5'd1;
    @(negedge clk);
    rand_val = 5'd2;
    repeat (5) @(negedge clk);
    rand_val = 5'd6;
    @(negedge clk);
    rand_val = 5'd3;
    repeat (4) @(negedge clk);
    place_req = 1'b0;
    wait_done(d0 + 2);

    // Reset asserted while in SY aborts with no done and no query.
    @(negedge clk);
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
    rand_val  = 5'd9;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_busy", busy, 0);

    place(5'd10, 5'd20, 5'd10, 5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5, 1, 0, 0, 5'd10, 5'd20);

`ifdef FOOD_SCAN_EN
    all_occ = 1; have_free = 1; fx = 5'd2; fy = 5'd0;
    place(5'd3, 5'd3, 5'd3, 5'd3, 5'd5, 5'd5, 5'd5, 5'd5, 0, 0, 15, 1, 0, 3, 5'd2, 5'd0);
    have_free = 0;
    place(5'd3, 5'd3, 5'd3, 5'd3, 5'd5, 5'd5, 5'd5, 5'd5, 0, 0, 1160, 0, 1, 576, 5'd0, 5'd0);
    all_occ = 0;
    place(5'd12, 5'd4, 5'd12, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5, 1, 0, 0, 5'd12, 5'd4);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("queries_drained", qq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
